// File: rtl/alu_issue_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_unit
// Description : Issues one operation at a time to a registered ALU, captures
//               the result, derives flags and a branch decision, and returns
//               them over a valid/ready response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_unit #(
    parameter int WORD_SIZE   = 16,
    parameter int ALU_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_op,
    input  logic [WORD_SIZE-1:0] req_a,
    input  logic [WORD_SIZE-1:0] req_b,
    input  logic [2:0]           req_cond,
    output logic [2:0]           alu_op,
    output logic [WORD_SIZE-1:0] alu_in1,
    output logic [WORD_SIZE-1:0] alu_in2,
    output logic                 alu_enable,
    input  logic [WORD_SIZE-1:0] alu_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WORD_SIZE-1:0] rsp_result,
    output logic                 rsp_zero,
    output logic                 rsp_sign,
    output logic                 rsp_carry,
    output logic                 rsp_ovf,
    output logic                 rsp_take
);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ISSUE = 2'd1;
    localparam logic [1:0] c_S_WAIT  = 2'd2;
    localparam logic [1:0] c_S_RESP  = 2'd3;

    localparam logic [2:0] c_OP_ADD   = 3'd0;
    localparam logic [2:0] c_OP_SUB   = 3'd1;
    localparam logic [2:0] c_OP_SHIFT = 3'd7;

    localparam logic [2:0] c_CC_ALWAYS = 3'd0;
    localparam logic [2:0] c_CC_EQ     = 3'd1;
    localparam logic [2:0] c_CC_NE     = 3'd2;
    localparam logic [2:0] c_CC_LT     = 3'd3;
    localparam logic [2:0] c_CC_GE     = 3'd4;
    localparam logic [2:0] c_CC_CS     = 3'd5;
    localparam logic [2:0] c_CC_CC     = 3'd6;

    localparam int             c_CNT_W    = 2;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(ALU_LATENCY - 1);

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic                 r_req_ready;
    logic [2:0]           r_alu_op;
    logic [WORD_SIZE-1:0] r_alu_in1;
    logic [WORD_SIZE-1:0] r_alu_in2;
    logic [2:0]           r_cond;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [WORD_SIZE-1:0] r_rsp_result;
    logic                 r_zero, r_sign, r_carry, r_ovf, r_take;

    logic w_req_fire;
    logic w_capture;
    logic w_a_msb, w_b_msb, w_r_msb;
    logic w_zero, w_sign, w_carry, w_ovf, w_take;
    logic w_shift_carry;

    assign w_req_fire = req_valid & r_req_ready;
    assign w_capture  = (r_state == c_S_WAIT) && (r_cnt == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE:  if (w_req_fire) w_next_state = c_S_ISSUE;
            c_S_ISSUE: w_next_state = c_S_WAIT;
            c_S_WAIT:  if (r_cnt == '0) w_next_state = c_S_RESP;
            c_S_RESP:  if (rsp_ready) w_next_state = c_S_IDLE;
            default:   w_next_state = c_S_IDLE;
        endcase
    end

    assign w_a_msb = r_alu_in1[WORD_SIZE-1];
    assign w_b_msb = r_alu_in2[WORD_SIZE-1];
    assign w_r_msb = alu_out[WORD_SIZE-1];
    assign w_zero  = (alu_out == '0);
    assign w_sign  = w_r_msb;

    // Carry out of a left shift is the last bit to leave the word
    always_comb begin
        w_shift_carry = 1'b0;
        for (int i = 1; i <= WORD_SIZE; i++) begin
            if (r_alu_in2 == WORD_SIZE'(i)) begin
                w_shift_carry = r_alu_in1[WORD_SIZE-i];
            end
        end
    end

    always_comb begin
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (r_alu_op)
            c_OP_ADD: begin
                w_carry = (w_a_msb & w_b_msb) | ((w_a_msb | w_b_msb) & ~w_r_msb);
                w_ovf   = (w_a_msb == w_b_msb) & (w_r_msb != w_a_msb);
            end
            c_OP_SUB: begin
                w_carry = (r_alu_in1 < r_alu_in2);
                w_ovf   = (w_a_msb != w_b_msb) & (w_r_msb != w_a_msb);
            end
            c_OP_SHIFT: w_carry = w_shift_carry;
            default: ;
        endcase
    end

    always_comb begin
        w_take = 1'b0;
        case (r_cond)
            c_CC_ALWAYS: w_take = 1'b1;
            c_CC_EQ:     w_take = w_zero;
            c_CC_NE:     w_take = ~w_zero;
            c_CC_LT:     w_take = w_sign ^ w_ovf;
            c_CC_GE:     w_take = ~(w_sign ^ w_ovf);
            c_CC_CS:     w_take = w_carry;
            c_CC_CC:     w_take = ~w_carry;
            default:     w_take = 1'b0;
        endcase
    end

    // Operand latch, latency counter and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_ready  <= 1'b0;
            r_alu_op     <= '0;
            r_alu_in1    <= '0;
            r_alu_in2    <= '0;
            r_cond       <= '0;
            r_cnt        <= '0;
            r_rsp_result <= '0;
            r_zero       <= 1'b0;
            r_sign       <= 1'b0;
            r_carry      <= 1'b0;
            r_ovf        <= 1'b0;
            r_take       <= 1'b0;
        end else begin
            r_req_ready <= (w_next_state == c_S_IDLE);
            if (w_req_fire) begin
                r_alu_op  <= req_op;
                r_alu_in1 <= req_a;
                r_alu_in2 <= req_b;
                r_cond    <= req_cond;
            end
            if (r_state == c_S_ISSUE) begin
                r_cnt <= c_CNT_LOAD;
            end else if ((r_state == c_S_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_capture) begin
                r_rsp_result <= alu_out;
                r_zero       <= w_zero;
                r_sign       <= w_sign;
                r_carry      <= w_carry;
                r_ovf        <= w_ovf;
                r_take       <= w_take;
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign alu_op     = r_alu_op;
    assign alu_in1    = r_alu_in1;
    assign alu_in2    = r_alu_in2;
    assign alu_enable = (r_state == c_S_ISSUE);
    assign rsp_valid  = (r_state == c_S_RESP);
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_zero;
    assign rsp_sign   = r_sign;
    assign rsp_carry  = r_carry;
    assign rsp_ovf    = r_ovf;
    assign rsp_take   = r_take;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_unit
// Description : Scoreboard bench for alu_issue_unit at ALU latency 1 and 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_unit;

    typedef struct packed {
        logic [15:0] res;
        logic        z;
        logic        s;
        logic        c;
        logic        v;
        logic        t;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [2:0]  req_op     [2];
    logic [15:0] req_a      [2];
    logic [15:0] req_b      [2];
    logic [2:0]  req_cond   [2];
    logic [2:0]  alu_op     [2];
    logic [15:0] alu_in1    [2];
    logic [15:0] alu_in2    [2];
    logic        alu_enable [2];
    logic [15:0] alu_out    [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic [15:0] rsp_result [2];
    logic        rsp_zero   [2];
    logic        rsp_sign   [2];
    logic        rsp_carry  [2];
    logic        rsp_ovf    [2];
    logic        rsp_take   [2];

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    logic [15:0] p0;
    logic [15:0] p1 [3];

    alu_issue_unit #(.WORD_SIZE(16), .ALU_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
        .req_a(req_a[0]), .req_b(req_b[0]), .req_cond(req_cond[0]),
        .alu_op(alu_op[0]), .alu_in1(alu_in1[0]), .alu_in2(alu_in2[0]),
        .alu_enable(alu_enable[0]), .alu_out(alu_out[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]),
        .rsp_zero(rsp_zero[0]), .rsp_sign(rsp_sign[0]), .rsp_carry(rsp_carry[0]),
        .rsp_ovf(rsp_ovf[0]), .rsp_take(rsp_take[0])
    );

    alu_issue_unit #(.WORD_SIZE(16), .ALU_LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
        .req_a(req_a[1]), .req_b(req_b[1]), .req_cond(req_cond[1]),
        .alu_op(alu_op[1]), .alu_in1(alu_in1[1]), .alu_in2(alu_in2[1]),
        .alu_enable(alu_enable[1]), .alu_out(alu_out[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]),
        .rsp_zero(rsp_zero[1]), .rsp_sign(rsp_sign[1]), .rsp_carry(rsp_carry[1]),
        .rsp_ovf(rsp_ovf[1]), .rsp_take(rsp_take[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a;
            3'd3: return b;
            3'd4: return a & b;
            3'd5: return a | b;
            3'd6: return a ^ b;
            default: return a << b;
        endcase
    endfunction

    // Registered ALU models; junk is loaded when not enabled so a mistimed capture shows up
    always @(posedge clk) begin
        p0    <= alu_enable[0] ? alu_fn(alu_op[0], alu_in1[0], alu_in2[0]) : 16'hDEAD;
        p1[0] <= alu_enable[1] ? alu_fn(alu_op[1], alu_in1[1], alu_in2[1]) : 16'hBEEF;
        p1[1] <= p1[0];
        p1[2] <= p1[1];
    end
    assign alu_out[0] = p0;
    assign alu_out[1] = p1[2];

    function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic [2:0] cond);
        exp_t        e;
        logic [16:0] wide;
        logic [15:0] tmp;
        int          si;
        e   = '0;
        e.res = alu_fn(op, a, b);
        case (op)
            3'd0: begin
                wide = {1'b0, a} + {1'b0, b};
                e.c  = wide[16];
                si   = $signed(a) + $signed(b);
                e.v  = (si > 32767) || (si < -32768);
            end
            3'd1: begin
                e.c = (a < b);
                si  = $signed(a) - $signed(b);
                e.v = (si > 32767) || (si < -32768);
            end
            3'd7: begin
                tmp = a;
                if (b >= 16'd1 && b <= 16'd16) begin
                    for (int i = 0; i < int'(b); i++) begin
                        e.c = tmp[15];
                        tmp = tmp << 1;
                    end
                end
            end
            default: ;
        endcase
        e.z = (e.res == 16'h0000);
        e.s = e.res[15];
        case (cond)
            3'd0: e.t = 1'b1;
            3'd1: e.t = e.z;
            3'd2: e.t = !e.z;
            3'd3: e.t = e.s ^ e.v;
            3'd4: e.t = !(e.s ^ e.v);
            3'd5: e.t = e.c;
            3'd6: e.t = !e.c;
            default: e.t = 1'b0;
        endcase
        return e;
    endfunction

    function automatic exp_t observed(input int u);
        return {rsp_result[u], rsp_zero[u], rsp_sign[u], rsp_carry[u], rsp_ovf[u], rsp_take[u]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input int u, input logic [2:0] op, input logic [15:0] a,
                             input logic [15:0] b, input logic [2:0] cond);
        int cyc;
        @(negedge clk);
        req_valid[u] = 1'b1;
        req_op[u]    = op;
        req_a[u]     = a;
        req_b[u]     = b;
        req_cond[u]  = cond;
        cyc = 0;
        while (!req_ready[u] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("accept_wait", 32'(cyc < 20), 32'd1);
        @(posedge clk);
        #1;
        req_valid[u] = 1'b0;
        req_op[u]    = 3'($urandom);
        req_a[u]     = 16'($urandom);
        req_b[u]     = 16'($urandom);
        req_cond[u]  = 3'($urandom);
    endtask

    task automatic run_op(input int u, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [2:0] cond, input int stall);
        exp_t e;
        exp_t first;
        int   cyc;
        int   en;
        sb.push_back(model(op, a, b, cond));
        rsp_ready[u] = (stall == 0);
        drive_req(u, op, a, b, cond);
        cyc = 0;
        en  = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (alu_enable[u]) en++;
        end while (!rsp_valid[u] && cyc < 20);
        chk("latency", 32'(cyc), (u == 0) ? 32'd3 : 32'd5);
        chk("enable_pulses", 32'(en), 32'd1);
        first = observed(u);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_hold", 32'(observed(u)), 32'(first));
            chk("stall_valid", 32'(rsp_valid[u]), 32'd1);
            chk("stall_req_ready", 32'(req_ready[u]), 32'd0);
            chk("stall_enable", 32'(alu_enable[u]), 32'd0);
        end
        rsp_ready[u] = 1'b1;
        e = sb.pop_front();
        chk("rsp_result", 32'(rsp_result[u]), 32'(e.res));
        chk("rsp_flags_zsco_take", 32'({rsp_zero[u], rsp_sign[u], rsp_carry[u], rsp_ovf[u], rsp_take[u]}),
            32'({e.z, e.s, e.c, e.v, e.t}));
        @(negedge clk);
        chk("post_hs_valid", 32'(rsp_valid[u]), 32'd0);
        chk("post_hs_req_ready", 32'(req_ready[u]), 32'd1);
        rsp_ready[u] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0;
            req_op[u]    = '0;
            req_a[u]     = '0;
            req_b[u]     = '0;
            req_cond[u]  = '0;
            rsp_ready[u] = 1'b0;
        end
        repeat (3) @(negedge clk);

        for (int u = 0; u < 2; u++) begin
            chk("reset_req_ready", 32'(req_ready[u]), 32'd0);
            chk("reset_alu", 32'({alu_enable[u], alu_op[u], alu_in1[u], alu_in2[u]}), 32'd0);
            chk("reset_rsp", 32'({rsp_valid[u], observed(u)}), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Latency-1 unit: directed operations
        run_op(0, 3'd0, 16'h7FFF, 16'h0001, 3'd3, 0);
        run_op(0, 3'd1, 16'h0005, 16'h0005, 3'd1, 0);
        run_op(0, 3'd1, 16'h0005, 16'h0005, 3'd2, 0);
        run_op(0, 3'd1, 16'h0001, 16'h0002, 3'd5, 5);
        run_op(0, 3'd7, 16'h8001, 16'h0001, 3'd5, 0);
        run_op(0, 3'd7, 16'h8001, 16'h0000, 3'd6, 0);
        run_op(0, 3'd7, 16'h0001, 16'd16,   3'd5, 0);
        run_op(0, 3'd7, 16'hFFFF, 16'd17,   3'd5, 0);
        run_op(0, 3'd0, 16'hFFFF, 16'h0001, 3'd5, 2);
        run_op(0, 3'd1, 16'h8000, 16'h0001, 3'd3, 0);
        run_op(0, 3'd4, 16'hF0F0, 16'h0FF0, 3'd2, 0);
        run_op(0, 3'd5, 16'h8000, 16'h0001, 3'd4, 0);
        run_op(0, 3'd6, 16'h1234, 16'h1234, 3'd1, 0);
        run_op(0, 3'd2, 16'h00AA, 16'h5555, 3'd7, 0);
        run_op(0, 3'd3, 16'h1111, 16'h8000, 3'd3, 0);

        // Reset while waiting on the ALU: the in-flight result must vanish
        rsp_ready[0] = 1'b1;
        drive_req(0, 3'd0, 16'h0100, 16'h0200, 3'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_enable", 32'(alu_enable[0]), 32'd0);
        chk("midrst_valid", 32'(rsp_valid[0]), 32'd0);
        chk("midrst_req_ready", 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_no_rsp", 32'(rsp_valid[0]), 32'd0);
        end
        chk("midrst_idle", 32'(req_ready[0]), 32'd1);
        run_op(0, 3'd0, 16'd2, 16'd3, 3'd0, 0);

        // Latency-3 unit
        run_op(1, 3'd0, 16'd2, 16'd3, 3'd0, 0);
        run_op(1, 3'd1, 16'h0001, 16'h0002, 3'd4, 3);
        run_op(1, 3'd7, 16'h4000, 16'h0002, 3'd5, 0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
